vdp_super_res_writer: RTL and testbench

Write-side companion to the super-res/super-mid scan-out path. Accepts CPU pixel bytes at an auto-incrementing 19-bit byte address. Packs them into 32-bit VRAM words with byte enables and buffers them in a 4-entry FIFO. Drains the FIFO to VRAM over a req/ack handshake only while the scan-out reader does not own the bus (`super_res_drawing` low).

---
 rtl/vdp_super_res_writer_if.sv | 24 ++
 rtl/vdp_super_res_writer.sv | 182 ++++++++++++++++++
 tb/tb_vdp_super_res_writer.sv | 368 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/vdp_super_res_writer_if.sv
// VRAM write port of the super-res writer: one word request held until acknowledged.
interface vdp_super_res_writer_if;
  logic        vram_wr_req;
  logic [16:0] vram_wr_addr;
  logic [31:0] vram_wr_data;
  logic [3:0]  vram_wr_be;
  logic        vram_wr_ack;

  modport master (
    output vram_wr_req,
    output vram_wr_addr,
    output vram_wr_data,
    output vram_wr_be,
    input  vram_wr_ack
  );

  modport slave (
    input  vram_wr_req,
    input  vram_wr_addr,
    input  vram_wr_data,
    input  vram_wr_be,
    output vram_wr_ack
  );
endinterface

// File: rtl/vdp_super_res_writer.sv
// CPU byte writer for super-res VRAM: packs bytes into words, buffers them, drains on req/ack.
// Byte packing is enabled by defining SUPER_RES_WRITE_COALESCE_EN; otherwise each byte is its own write.
//
// state  | meaning
// S_IDLE | no request outstanding; loads FIFO head when non-empty and bus is free
// S_REQ  | vram_wr_req high with stable addr/data/be, waiting for vram_wr_ack
module vdp_super_res_writer #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        vdp_super,
  input  logic        super_res_drawing,
  input  logic        addr_set,
  input  logic [18:0] addr_in,
  input  logic        data_wr,
  input  logic [7:0]  data_in,
  input  logic        flush,
  output logic        busy,
  output logic        overflow,
  output logic [18:0] wr_ptr,
  output logic [2:0]  fifo_level,
  vdp_super_res_writer_if.master vram
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int LW = $clog2(FIFO_DEPTH + 1);

  typedef struct packed {
    logic [16:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
  } entry_t;

  typedef enum logic {
    S_IDLE,
    S_REQ
  } state_t;

  state_t          state;
  entry_t          mem [FIFO_DEPTH];
  logic [AW-1:0]   head;
  logic [AW-1:0]   tail;
  logic [LW-1:0]   count;
  entry_t          asm_q;
  logic            asm_valid;

  logic [1:0]      lane;
  logic            full;
  logic            wr_take;
  logic            wr_drop;
  logic            wr_push;
  logic [31:0]     lane_data;
  logic [3:0]      lane_be;
  entry_t          merged;
  entry_t          push_entry;
  entry_t          asm_d;
  logic            asm_valid_d;
  logic            push_req;
  logic            push_ok;
  logic            push_drop;
  logic            pop;
  logic [LW-1:0]   count_next;

  assign lane      = wr_ptr[1:0];
  assign full      = (count == LW'(FIFO_DEPTH));
  // addr_set wins over a coincident data_wr, which is then silently ignored
  assign wr_take   = data_wr & ~addr_set & ~full;
  assign wr_drop   = data_wr & ~addr_set & full;
  assign lane_data = 32'(data_in) << {lane, 3'b000};
  assign lane_be   = 4'b0001 << lane;

`ifdef SUPER_RES_WRITE_COALESCE_EN
  always_comb begin
    merged.addr = wr_ptr[18:2];
    merged.data = (asm_q.data & ~(32'h0000_00FF << {lane, 3'b000})) | lane_data;
    merged.be   = asm_q.be | lane_be;
    wr_push     = wr_take & (lane == 2'd3);
  end
`else
  always_comb begin
    merged.addr = wr_ptr[18:2];
    merged.data = lane_data;
    merged.be   = lane_be;
    wr_push     = wr_take;
  end
`endif

  always_comb begin
    push_req   = addr_set ? asm_valid : (wr_push | (flush & (asm_valid | wr_take)));
    push_entry = wr_take ? merged : asm_q;
    push_ok    = push_req & ~full;
    push_drop  = push_req & full;
    pop        = (state == S_REQ) & vram.vram_wr_ack;
    count_next = count + LW'(push_ok) - LW'(pop);
  end

  // Any push (or dropped push) empties the assembly; otherwise an accepted byte is merged in.
  always_comb begin
    asm_d       = asm_q;
    asm_valid_d = asm_valid;
`ifdef SUPER_RES_WRITE_COALESCE_EN
    if (addr_set || push_req) begin
      asm_d       = '0;
      asm_valid_d = 1'b0;
    end else if (wr_take) begin
      asm_d       = merged;
      asm_valid_d = 1'b1;
    end
`else
    asm_d       = '0;
    asm_valid_d = 1'b0;
`endif
  end

  always_ff @(posedge clk) begin
    if (!reset_n || !vdp_super) begin
      state             <= S_IDLE;
      head              <= '0;
      tail              <= '0;
      count             <= '0;
      asm_q             <= '0;
      asm_valid         <= 1'b0;
      wr_ptr            <= '0;
      overflow          <= 1'b0;
      busy              <= 1'b0;
      vram.vram_wr_req  <= 1'b0;
      vram.vram_wr_addr <= '0;
      vram.vram_wr_data <= '0;
      vram.vram_wr_be   <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      asm_q     <= asm_d;
      asm_valid <= asm_valid_d;
      count     <= count_next;
      busy      <= (count_next == LW'(FIFO_DEPTH));

      if (addr_set) begin
        wr_ptr <= addr_in;
      end else if (wr_take) begin
        wr_ptr <= wr_ptr + 19'd1;
      end

      // a dropped push during addr_set still reports, so set beats clear
      if (wr_drop || push_drop) begin
        overflow <= 1'b1;
      end else if (addr_set) begin
        overflow <= 1'b0;
      end

      if (push_ok) begin
        mem[tail] <= push_entry;
        tail      <= tail + AW'(1);
      end

      case (state)
        S_IDLE: begin
          if ((count != '0) && !super_res_drawing) begin
            vram.vram_wr_addr <= mem[head].addr;
            vram.vram_wr_data <= mem[head].data;
            vram.vram_wr_be   <= mem[head].be;
            vram.vram_wr_req  <= 1'b1;
            state             <= S_REQ;
          end
        end
        S_REQ: begin
          if (vram.vram_wr_ack) begin
            vram.vram_wr_req <= 1'b0;
            head             <= head + AW'(1);
            state            <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign fifo_level = 3'(count);

endmodule

// File: tb/tb_vdp_super_res_writer.sv
// Directed bench for vdp_super_res_writer: transaction vector table plus hand sequences.
module tb_vdp_super_res_writer;

`ifdef SUPER_RES_WRITE_COALESCE_EN
  localparam int BPW = 4;
`else
  localparam int BPW = 1;
`endif

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        vdp_super = 1'b1;
  logic        super_res_drawing = 1'b0;
  logic        addr_set = 1'b0;
  logic [18:0] addr_in = '0;
  logic        data_wr = 1'b0;
  logic [7:0]  data_in = '0;
  logic        flush = 1'b0;
  logic        busy;
  logic        overflow;
  logic [18:0] wr_ptr;
  logic [2:0]  fifo_level;

  vdp_super_res_writer_if vif ();

  vdp_super_res_writer #(.FIFO_DEPTH(4)) dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .vdp_super         (vdp_super),
    .super_res_drawing (super_res_drawing),
    .addr_set          (addr_set),
    .addr_in           (addr_in),
    .data_wr           (data_wr),
    .data_in           (data_in),
    .flush             (flush),
    .busy              (busy),
    .overflow          (overflow),
    .wr_ptr            (wr_ptr),
    .fifo_level        (fifo_level),
    .vram              (vif)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [16:0] cap_a [$];
  logic [31:0] cap_d [$];
  logic [3:0]  cap_be [$];

  always @(posedge clk) begin
    if (vif.vram_wr_req && vif.vram_wr_ack) begin
      cap_a.push_back(vif.vram_wr_addr);
      cap_d.push_back(vif.vram_wr_data);
      cap_be.push_back(vif.vram_wr_be);
    end
  end

  typedef struct {
    logic [18:0]       addr;
    int                n;
    logic [3:0][7:0]   b;
    int                fin;   // 0 none, 1 flush, 2 addr_set 0x00200
    int                nreq;
    logic [3:0][16:0]  ea;
    logic [3:0][31:0]  ed;
    logic [3:0][3:0]   ebe;
    logic [18:0]       eptr;
  } vec_t;

  vec_t vecs [5];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic wr(input logic [7:0] b);
    data_wr = 1'b1;
    data_in = b;
    tick();
    data_wr = 1'b0;
  endtask

  task automatic set_addr(input logic [18:0] a);
    addr_set = 1'b1;
    addr_in  = a;
    tick();
    addr_set = 1'b0;
  endtask

  task automatic push_words(input logic [18:0] a, input int n);
    set_addr(a);
    for (int i = 0; i < n * BPW; i++) wr(8'(i + 1));
  endtask

  task automatic clear_cap();
    cap_a.delete();
    cap_d.delete();
    cap_be.delete();
  endtask

  task automatic wait_req(input string nm);
    int t = 0;
    while (!vif.vram_wr_req && t < 20) begin
      tick();
      t++;
    end
    chk(nm, {31'b0, vif.vram_wr_req}, 32'd1);
  endtask

  task automatic drain();
    int t = 0;
    while ((fifo_level != 3'd0 || vif.vram_wr_req) && t < 100) begin
      if (vif.vram_wr_req) begin
        tick();
        tick();
        vif.vram_wr_ack = 1'b1;
        tick();
        vif.vram_wr_ack = 1'b0;
      end else begin
        tick();
      end
      t++;
    end
    chk("drain_done", {31'b0, (fifo_level == 3'd0) && !vif.vram_wr_req}, 32'd1);
  endtask

  task automatic chk_entry(input string nm, input int i, input logic [16:0] a,
                           input logic [31:0] d, input logic [3:0] be);
    if (i < cap_a.size()) begin
      chk({nm, "_addr"}, 32'(cap_a[i]), 32'(a));
      chk({nm, "_data"}, cap_d[i], d);
      chk({nm, "_be"}, 32'(cap_be[i]), 32'(be));
    end else begin
      chk({nm, "_missing"}, 32'(cap_a.size()), 32'(i + 1));
    end
  endtask

  task automatic chk_reset_state(input string nm);
    chk({nm, "_req"}, {31'b0, vif.vram_wr_req}, 32'd0);
    chk({nm, "_level"}, 32'(fifo_level), 32'd0);
    chk({nm, "_ptr"}, 32'(wr_ptr), 32'd0);
    chk({nm, "_ovf"}, {31'b0, overflow}, 32'd0);
    chk({nm, "_busy"}, {31'b0, busy}, 32'd0);
    chk({nm, "_bus"}, {vif.vram_wr_data ^ 32'(vif.vram_wr_addr), 28'b0, vif.vram_wr_be}, 32'd0);
  endtask

  logic [16:0] h1_a1;
  logic [31:0] h1_d0, h1_d1;
  logic [3:0]  h1_be0, h1_be1;
  logic [18:0] ptr_hold;

  initial begin
    vif.vram_wr_ack = 1'b0;

`ifdef SUPER_RES_WRITE_COALESCE_EN
    vecs[0] = '{addr:19'h00100, n:4, b:{8'h44,8'h33,8'h22,8'h11}, fin:0, nreq:1,
                ea:{17'h0,17'h0,17'h0,17'h00040},
                ed:{32'h0,32'h0,32'h0,32'h44332211},
                ebe:{4'h0,4'h0,4'h0,4'hF}, eptr:19'h00104};
    vecs[1] = '{addr:19'h7FFFE, n:3, b:{8'h00,8'hCC,8'hBB,8'hAA}, fin:1, nreq:2,
                ea:{17'h0,17'h0,17'h00000,17'h1FFFF},
                ed:{32'h0,32'h0,32'h000000CC,32'hBBAA0000},
                ebe:{4'h0,4'h0,4'h1,4'hC}, eptr:19'h00001};
    vecs[2] = '{addr:19'h00005, n:2, b:{8'h00,8'h00,8'hA5,8'h5A}, fin:1, nreq:1,
                ea:{17'h0,17'h0,17'h0,17'h00001},
                ed:{32'h0,32'h0,32'h0,32'h00A55A00},
                ebe:{4'h0,4'h0,4'h0,4'h6}, eptr:19'h00007};
    vecs[4] = '{addr:19'h00020, n:4, b:{8'h04,8'h03,8'h02,8'h01}, fin:1, nreq:1,
                ea:{17'h0,17'h0,17'h0,17'h00008},
                ed:{32'h0,32'h0,32'h0,32'h04030201},
                ebe:{4'h0,4'h0,4'h0,4'hF}, eptr:19'h00024};
    h1_d0 = 32'h04030201; h1_be0 = 4'hF;
    h1_a1 = 17'h000C1; h1_d1 = 32'h08070605; h1_be1 = 4'hF;
`else
    vecs[0] = '{addr:19'h00100, n:4, b:{8'h44,8'h33,8'h22,8'h11}, fin:0, nreq:4,
                ea:{17'h00040,17'h00040,17'h00040,17'h00040},
                ed:{32'h44000000,32'h00330000,32'h00002200,32'h00000011},
                ebe:{4'h8,4'h4,4'h2,4'h1}, eptr:19'h00104};
    vecs[1] = '{addr:19'h7FFFE, n:3, b:{8'h00,8'hCC,8'hBB,8'hAA}, fin:1, nreq:3,
                ea:{17'h0,17'h00000,17'h1FFFF,17'h1FFFF},
                ed:{32'h0,32'h000000CC,32'hBB000000,32'h00AA0000},
                ebe:{4'h0,4'h1,4'h8,4'h4}, eptr:19'h00001};
    vecs[2] = '{addr:19'h00005, n:2, b:{8'h00,8'h00,8'hA5,8'h5A}, fin:1, nreq:2,
                ea:{17'h0,17'h0,17'h00001,17'h00001},
                ed:{32'h0,32'h0,32'h00A50000,32'h00005A00},
                ebe:{4'h0,4'h0,4'h4,4'h2}, eptr:19'h00007};
    vecs[4] = '{addr:19'h00020, n:4, b:{8'h04,8'h03,8'h02,8'h01}, fin:1, nreq:4,
                ea:{17'h00008,17'h00008,17'h00008,17'h00008},
                ed:{32'h04000000,32'h00030000,32'h00000200,32'h00000001},
                ebe:{4'h8,4'h4,4'h2,4'h1}, eptr:19'h00024};
    h1_d0 = 32'h00000001; h1_be0 = 4'h1;
    h1_a1 = 17'h000C0; h1_d1 = 32'h00000200; h1_be1 = 4'h2;
`endif
    vecs[3] = '{addr:19'h00010, n:1, b:{8'h00,8'h00,8'h00,8'h01}, fin:2, nreq:1,
                ea:{17'h0,17'h0,17'h0,17'h00004},
                ed:{32'h0,32'h0,32'h0,32'h00000001},
                ebe:{4'h0,4'h0,4'h0,4'h1}, eptr:19'h00200};

    // reset
    repeat (3) tick();
    chk_reset_state("reset");
    reset_n = 1'b1;
    tick();

    // transaction table
    for (int v = 0; v < 5; v++) begin
      clear_cap();
      set_addr(vecs[v].addr);
      for (int i = 0; i < vecs[v].n; i++) wr(vecs[v].b[i]);
      if (vecs[v].fin == 1) begin
        flush = 1'b1;
        tick();
        flush = 1'b0;
      end else if (vecs[v].fin == 2) begin
        set_addr(19'h00200);
      end
      drain();
      chk($sformatf("vec%0d_nreq", v), 32'(cap_a.size()), 32'(vecs[v].nreq));
      for (int i = 0; i < vecs[v].nreq; i++)
        chk_entry($sformatf("vec%0d_req%0d", v, i), i, vecs[v].ea[i], vecs[v].ed[i], vecs[v].ebe[i]);
      chk($sformatf("vec%0d_ptr", v), 32'(wr_ptr), 32'(vecs[v].eptr));
      chk($sformatf("vec%0d_ovf", v), {31'b0, overflow}, 32'd0);
    end

    // lane-3 write latency: req high one edge after the push
    clear_cap();
    set_addr(19'h00003);
    wr(8'h77);
    chk("lat_level", 32'(fifo_level), 32'd1);
    chk("lat_req_early", {31'b0, vif.vram_wr_req}, 32'd0);
    tick();
    chk("lat_req", {31'b0, vif.vram_wr_req}, 32'd1);
    drain();
    chk_entry("lat", 0, 17'h00000, 32'h77000000, 4'h8);

    // bus blocking, ordering and the post-ack gap
    clear_cap();
    super_res_drawing = 1'b1;
    push_words(19'h00300, 2);
    begin
      int seen = 0;
      for (int i = 0; i < 5; i++) begin
        if (vif.vram_wr_req) seen++;
        tick();
      end
      chk("block_no_req", 32'(seen), 32'd0);
    end
    chk("block_level", 32'(fifo_level), 32'd2);
    super_res_drawing = 1'b0;
    wait_req("block_req1");
    vif.vram_wr_ack = 1'b1;
    tick();
    vif.vram_wr_ack = 1'b0;
    chk("gap_req_low", {31'b0, vif.vram_wr_req}, 32'd0);
    tick();
    chk("gap_req_next", {31'b0, vif.vram_wr_req}, 32'd1);
    vif.vram_wr_ack = 1'b1;
    tick();
    vif.vram_wr_ack = 1'b0;
    tick();
    chk("block_nreq", 32'(cap_a.size()), 32'd2);
    chk_entry("block0", 0, 17'h000C0, h1_d0, h1_be0);
    chk_entry("block1", 1, h1_a1, h1_d1, h1_be1);

    // drawing rising mid-REQ keeps the request up until ack
    push_words(19'h00340, 1);
    wait_req("midreq_req");
    super_res_drawing = 1'b1;
    begin
      int low = 0;
      for (int i = 0; i < 3; i++) begin
        tick();
        if (!vif.vram_wr_req) low++;
      end
      chk("midreq_held", 32'(low), 32'd0);
    end
    vif.vram_wr_ack = 1'b1;
    tick();
    vif.vram_wr_ack = 1'b0;
    chk("midreq_dropped", {31'b0, vif.vram_wr_req}, 32'd0);
    super_res_drawing = 1'b0;
    drain();

    // overflow with no ack
    push_words(19'h00400, 4);
    chk("ovf_busy", {31'b0, busy}, 32'd1);
    chk("ovf_level_full", 32'(fifo_level), 32'd4);
    ptr_hold = 19'h00400 + 19'(4 * BPW);
    wr(8'h99);
    chk("ovf_flag", {31'b0, overflow}, 32'd1);
    chk("ovf_ptr_hold", 32'(wr_ptr), 32'(ptr_hold));
    chk("ovf_level", 32'(fifo_level), 32'd4);
    set_addr(19'h00500);
    chk("ovf_cleared", {31'b0, overflow}, 32'd0);
    chk("ovf_new_ptr", 32'(wr_ptr), 32'h00500);

    // reset during REQ with three entries queued
    vif.vram_wr_ack = 1'b1;
    tick();
    vif.vram_wr_ack = 1'b0;
    tick();
    chk("rst_pre_level", 32'(fifo_level), 32'd3);
    chk("rst_pre_req", {31'b0, vif.vram_wr_req}, 32'd1);
    reset_n = 1'b0;
    tick();
    chk_reset_state("rst_mid");
    reset_n = 1'b1;
    tick();

    push_words(19'h00800, 3);
    tick();
    chk("dis_pre_level", 32'(fifo_level), 32'd3);
    chk("dis_pre_req", {31'b0, vif.vram_wr_req}, 32'd1);
    vdp_super = 1'b0;
    tick();
    chk_reset_state("dis_mid");
    vdp_super = 1'b1;
    tick();

    // addr_set beats a coincident data_wr; flush with empty assembly does nothing
    addr_set = 1'b1;
    addr_in  = 19'h00600;
    data_wr  = 1'b1;
    data_in  = 8'hEE;
    tick();
    addr_set = 1'b0;
    data_wr  = 1'b0;
    chk("prio_ptr", 32'(wr_ptr), 32'h00600);
    chk("prio_ovf", {31'b0, overflow}, 32'd0);
    chk("prio_level", 32'(fifo_level), 32'd0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    tick();
    chk("empty_flush_level", 32'(fifo_level), 32'd0);
    chk("empty_flush_req", {31'b0, vif.vram_wr_req}, 32'd0);

    // flush together with data_wr: merge then push
    clear_cap();
    set_addr(19'h00700);
    data_wr = 1'b1;
    data_in = 8'h12;
    flush   = 1'b1;
    tick();
    data_wr = 1'b0;
    flush   = 1'b0;
    chk("fw_level", 32'(fifo_level), 32'd1);
    chk("fw_ptr", 32'(wr_ptr), 32'h00701);
    drain();
    chk("fw_nreq", 32'(cap_a.size()), 32'd1);
    chk_entry("fw", 0, 17'h001C0, 32'h00000012, 4'h1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
